lif_neuron: RTL

- Leaky integrate-and-fire neuron that sits directly upstream of the STDP stage.
- Integrates weighted presynaptic spikes into a membrane potential, applies periodic linear leak, and emits the single-cycle post_spike the STDP stage consumes.
- Consumes the STDP stage's packed 16-bit weight bus (4 synapses x 4 bits), closing the learning loop.

---
 rtl/lif_neuron_if.sv | 25 ++
 rtl/lif_neuron.sv | 110 +++++++++++
 2 files changed

// File: rtl/lif_neuron_if.sv
// Bus bundle between a leaky integrate-and-fire neuron and its driver:
// presynaptic spikes, packed weights, enable, and the neuron's observable state.
interface lif_neuron_if #(
  parameter int NUM_PRE   = 4,
  parameter int W_WIDTH   = 4,
  parameter int POT_WIDTH = 8
);
  logic                       en;
  logic [NUM_PRE-1:0]         pre_spike;
  logic [NUM_PRE*W_WIDTH-1:0] weight;
  logic                       post_spike;
  logic [POT_WIDTH-1:0]       membrane;
  logic                       refractory;
  logic [7:0]                 spike_count;

  modport master (
    output en, pre_spike, weight,
    input  post_spike, membrane, refractory, spike_count
  );

  modport slave (
    input  en, pre_spike, weight,
    output post_spike, membrane, refractory, spike_count
  );
endinterface

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted spike integration, periodic linear
// leak, clamped membrane, threshold fire with optional refractory period.
module lif_neuron #(
  parameter int NUM_PRE       = 4,
  parameter int W_WIDTH       = 4,
  parameter int POT_WIDTH     = 8,
  parameter int THRESHOLD     = 32,
  parameter int LEAK_PERIOD   = 4,
  parameter int LEAK_AMT      = 1,
  parameter int REFRAC_CYCLES = 3
) (
  input logic         clk,
  input logic         rst,
  lif_neuron_if.slave bus
);

  localparam int SUM_W = W_WIDTH + ((NUM_PRE > 1) ? $clog2(NUM_PRE) : 0);
  localparam int MAX_W = (POT_WIDTH > SUM_W) ? POT_WIDTH : SUM_W;
  localparam int NXT_W = MAX_W + 2;
  localparam int LC_W  = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RC_W  = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
  localparam logic [NXT_W-1:0] MAX_POT = NXT_W'({POT_WIDTH{1'b1}});

  typedef enum logic {INTEGRATE, REFRAC} state_t;

  state_t               state;
  logic [POT_WIDTH-1:0] membrane;
  logic                 post_spike;
  logic [7:0]           spike_count;
  logic [LC_W-1:0]      leak_cnt;
  logic [RC_W-1:0]      refrac_cnt;

  logic [SUM_W-1:0]     syn_sum;
  logic                 tick;
  logic [LC_W-1:0]      leak_nxt;
  logic [NXT_W-1:0]     nxt;
  logic [POT_WIDTH-1:0] pot_clamp;
  logic                 fire;

  always_comb begin
    syn_sum = '0;
    for (int unsigned i = 0; i < NUM_PRE; i++) begin
      if (bus.pre_spike[i])
        syn_sum += SUM_W'(bus.weight[(NUM_PRE-1-i)*W_WIDTH +: W_WIDTH]);
    end
  end

  // nxt is two's complement; the two headroom bits keep its MSB a true sign bit
  always_comb begin
    tick     = (leak_cnt == LC_W'(LEAK_PERIOD - 1));
    leak_nxt = tick ? '0 : leak_cnt + 1'b1;
    nxt      = NXT_W'(membrane) + NXT_W'(syn_sum)
             - (tick ? NXT_W'(LEAK_AMT) : '0);
    if (nxt[NXT_W-1])
      pot_clamp = '0;
    else if (nxt > MAX_POT)
      pot_clamp = '1;
    else
      pot_clamp = nxt[POT_WIDTH-1:0];
    fire = (32'(pot_clamp) >= 32'(THRESHOLD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INTEGRATE;
      membrane    <= '0;
      post_spike  <= 1'b0;
      spike_count <= '0;
      leak_cnt    <= '0;
      refrac_cnt  <= '0;
    end else if (!bus.en) begin
      post_spike <= 1'b0;
    end else begin
      case (state)
        INTEGRATE: begin
          if (fire) begin
            post_spike <= 1'b1;
            membrane   <= '0;
            leak_cnt   <= '0;
            if (spike_count != '1)
              spike_count <= spike_count + 8'd1;
            if (REFRAC_CYCLES > 0) begin
              state      <= REFRAC;
              refrac_cnt <= RC_W'(REFRAC_CYCLES);
            end
          end else begin
            post_spike <= 1'b0;
            membrane   <= pot_clamp;
            leak_cnt   <= leak_nxt;
          end
        end
        REFRAC: begin
          post_spike <= 1'b0;
          membrane   <= '0;
          leak_cnt   <= '0;
          refrac_cnt <= refrac_cnt - 1'b1;
          if (refrac_cnt == RC_W'(1))
            state <= INTEGRATE;
        end
        default: state <= INTEGRATE;
      endcase
    end
  end

  assign bus.post_spike  = post_spike;
  assign bus.membrane    = membrane;
  assign bus.refractory  = (state == REFRAC);
  assign bus.spike_count = spike_count;

endmodule
